// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with debounce, one-deep key
// holding register, consumer acknowledge and a sticky overrun flag.
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  input  logic       key_ack,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_PRS  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [3:0]    r_rs1, r_rs, r_pat, r_key_code;
  logic [DW-1:0] r_div;
  logic [1:0]    r_state, r_col_idx, r_row_idx;
  logic [CW-1:0] r_cnt;
  logic          r_key_valid, r_overrun;
  logic          w_tick, w_one_low, w_all_high, w_last, w_publish;
  logic [1:0]    w_low_idx;

  assign w_tick     = r_div == DW'(SCAN_DIV - 1);
  assign w_all_high = r_rs == 4'hF;
  assign w_one_low  = $onehot(~r_rs);
  assign w_low_idx  = !r_rs[0] ? 2'd0 : !r_rs[1] ? 2'd1 : !r_rs[2] ? 2'd2 : 2'd3;
  assign w_last     = r_cnt == CW'(DEBOUNCE_CNT - 1);
  assign w_publish  = w_tick && r_state == S_DEB && r_rs == r_pat && w_last;

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_down  = r_state == S_PRS || r_state == S_REL;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1     <= 4'hF;
      r_rs      <= 4'hF;
      r_pat     <= 4'hF;
      r_div     <= '0;
      r_state   <= S_SCAN;
      r_col_idx <= '0;
      r_row_idx <= '0;
      r_cnt     <= '0;
    end else begin
      r_rs1 <= row;
      r_rs  <= r_rs1;
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_one_low) begin
              r_row_idx <= w_low_idx;
              r_pat     <= r_rs;
              r_cnt     <= '0;
              r_state   <= S_DEB;
            end else begin
              r_col_idx <= r_col_idx + 1'b1;
            end
          end
          S_DEB: begin
            if (r_rs != r_pat) begin
              r_state   <= S_SCAN;
              r_col_idx <= r_col_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (w_last) r_state <= S_PRS;
            end
          end
          S_PRS: begin
            if (w_all_high) begin
              r_state <= S_REL;
              r_cnt   <= '0;
            end
          end
          default: begin
            if (!w_all_high) begin
              r_state <= S_PRS;
            end else if (w_last) begin
              r_state   <= S_SCAN;
              r_col_idx <= r_col_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // An ack arriving with a publish frees the holder for the new key at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_publish) begin
      if (!r_key_valid || key_ack) begin
        r_key_code  <= {r_row_idx, r_col_idx};
        r_key_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (key_ack && r_key_valid) begin
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of keypad_scan with a behavioural keypad that
// pulls the pressed key's row low only while its column is driven.
module tb_keypad_scan;
  logic       clk, rst, key_ack, key_on;
  logic [1:0] key_r, key_c;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_down, overrun;
  int         n_tot, n_bad;

  assign row = (key_on && !col[key_c]) ? ~(4'b0001 << key_r) : 4'hF;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk), .rst(rst), .row(row), .key_ack(key_ack), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  initial begin
    n_tot = 0; n_bad = 0;
    rst = 1'b1; key_ack = 1'b0; key_on = 1'b0; key_r = '0; key_c = '0;
    step(2);
    chk("rst_col", 8'(col), 8'he);
    chk("rst_code", 8'(key_code), 8'h0);
    chk("rst_valid", 8'(key_valid), 8'h0);
    chk("rst_down", 8'(key_down), 8'h0);
    chk("rst_ovr", 8'(overrun), 8'h0);
    rst = 1'b0;
    step(3); chk("idle_hold", 8'(col), 8'he);
    step(1); chk("idle_c1", 8'(col), 8'hd);
    step(4); chk("idle_c2", 8'(col), 8'hb);
    step(4); chk("idle_c3", 8'(col), 8'h7);
    step(4); chk("idle_wrap", 8'(col), 8'he);
    press(2'd2, 2'd0);
    step(4);
    key_on = 1'b0;
    step(3); chk("bounce_hold", 8'(col), 8'he);
    step(1);
    chk("bounce_col", 8'(col), 8'hd);
    chk("bounce_valid", 8'(key_valid), 8'h0);
    chk("bounce_down", 8'(key_down), 8'h0);
    step(4); chk("bounce_step", 8'(col), 8'hb);
    step(12); chk("align_c1", 8'(col), 8'hd);
    press(2'd2, 2'd1);
    step(11);
    chk("p9_pre_valid", 8'(key_valid), 8'h0);
    chk("p9_pre_down", 8'(key_down), 8'h0);
    chk("p9_frozen", 8'(col), 8'hd);
    step(1);
    chk("p9_code", 8'(key_code), 8'h9);
    chk("p9_valid", 8'(key_valid), 8'h1);
    chk("p9_down", 8'(key_down), 8'h1);
    key_on = 1'b0;
    step(11); chk("p9_rel_pre", 8'(key_down), 8'h1);
    step(1);
    chk("p9_rel_down", 8'(key_down), 8'h0);
    chk("p9_rel_col", 8'(col), 8'hb);
    chk("p9_rel_valid", 8'(key_valid), 8'h1);
    step(8); chk("align_c0", 8'(col), 8'he);
    press(2'd0, 2'd0);
    step(11); chk("ovr_pre", 8'(overrun), 8'h0);
    step(1);
    chk("ovr_set", 8'(overrun), 8'h1);
    chk("ovr_code", 8'(key_code), 8'h9);
    chk("ovr_valid", 8'(key_valid), 8'h1);
    key_on = 1'b0;
    step(12);
    chk("p0_rel_down", 8'(key_down), 8'h0);
    chk("p0_rel_col", 8'(col), 8'hd);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("ack_valid", 8'(key_valid), 8'h0);
    chk("ack_ovr", 8'(overrun), 8'h0);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("ack_idle", 8'(key_valid), 8'h0);
    step(2); chk("align_c2", 8'(col), 8'hb);
    press(2'd1, 2'd2);
    step(8); chk("mid_deb_col", 8'(col), 8'hb);
    rst = 1'b1; key_on = 1'b0;
    step(1);
    chk("mrst_col", 8'(col), 8'he);
    chk("mrst_code", 8'(key_code), 8'h0);
    chk("mrst_valid", 8'(key_valid), 8'h0);
    chk("mrst_down", 8'(key_down), 8'h0);
    chk("mrst_ovr", 8'(overrun), 8'h0);
    rst = 1'b0;
    step(24);
    chk("mrst_after_valid", 8'(key_valid), 8'h0);
    chk("mrst_after_col", 8'(col), 8'hb);
    press(2'd0, 2'd2);
    step(12);
    chk("p2_code", 8'(key_code), 8'h2);
    chk("p2_valid", 8'(key_valid), 8'h1);
    key_on = 1'b0;
    step(12);
    chk("p2_rel_col", 8'(col), 8'h7);
    chk("p2_rel_down", 8'(key_down), 8'h0);
    press(2'd3, 2'd3);
    step(11); chk("pf_pre_code", 8'(key_code), 8'h2);
    key_ack = 1'b1; step(1); key_ack = 1'b0;
    chk("pf_ack_code", 8'(key_code), 8'hf);
    chk("pf_ack_valid", 8'(key_valid), 8'h1);
    chk("pf_ack_ovr", 8'(overrun), 8'h0);
    step(1); chk("pf_hold_valid", 8'(key_valid), 8'h1);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per scan tick; legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive matching ticks needed to accept a press or a release; legal range >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port row  input  4  keypad row lines; active-low, pulled up; asynchronous to clk.
REQ-006 SHALL have port key_ack  input  1  consumer acknowledge of the held key.
REQ-007 SHALL have port col  output  4  column drive; active-low, exactly one bit low at all times.
REQ-008 SHALL have port key_code  output  4  accepted key, row_idx*4 + col_idx.
REQ-009 SHALL have port key_valid  output  1  key_code holds an unacknowledged key.
REQ-010 SHALL have port key_down  output  1  a debounced key is currently held.
REQ-011 SHALL have port overrun  output  1  sticky flag: a press was accepted while key_valid was already 1.

Function
REQ-012 SHALL pass row through a 2-flop synchronizer; all decisions SHALL use the synchronized value rs.
REQ-013 SHALL generate a one-cycle tick every SCAN_DIV clk cycles from a free-running divider.
REQ-014 SHALL drive col = ~(4'b0001 << col_idx), with col_idx in 0..3.
REQ-015 SHALL implement states SCAN, DEBOUNCE, PRESSED and RELEASE; the state SHALL change only on tick.
REQ-016 SCAN, tick, rs has exactly one low bit: SHALL capture row_idx and the rs pattern, clear the debounce count, and go to DEBOUNCE; col_idx SHALL hold.
REQ-017 SCAN, tick, rs = 4'hF or more than one bit low: SHALL advance col_idx (wrap 3 -> 0) and stay in SCAN.
REQ-018 DEBOUNCE, tick, rs equals the captured pattern: SHALL increment the count; on the DEBOUNCE_CNT-th match it SHALL publish (REQ-021) and go to PRESSED.
REQ-019 DEBOUNCE, tick, rs differs from the captured pattern: SHALL go to SCAN and advance col_idx; nothing is published.
REQ-020 PRESSED, tick, rs = 4'hF: SHALL go to RELEASE with the count cleared. RELEASE, tick, rs = 4'hF: SHALL increment the count; on the DEBOUNCE_CNT-th tick it SHALL go to SCAN and advance col_idx. RELEASE, tick, any row low: SHALL return to PRESSED.
REQ-021 Publish with key_valid = 0, or with key_ack = 1 in the same cycle: SHALL load key_code and set key_valid = 1 on the next clk edge; overrun is unchanged.
REQ-022 Publish with key_valid = 1 and key_ack = 0: SHALL set overrun = 1 and leave key_code unchanged.
REQ-023 key_ack = 1 with key_valid = 1 and no publish: SHALL clear key_valid and overrun on the next edge. key_ack with key_valid = 0 SHALL be ignored.
REQ-024 key_down SHALL be 1 exactly while the state is PRESSED or RELEASE.
REQ-025 key_code, key_valid and overrun SHALL be registered outputs, and key_code SHALL stay stable while key_valid = 1.

Reset
REQ-026 rst = 1 at a clk edge SHALL, at that edge, set: state = SCAN; col_idx = 0 (col = 4'b1110); divider, debounce count and synchronizer cleared (synchronizer to 4'hF); key_code = 0, key_valid = 0, key_down = 0, overrun = 0.
REQ-027 rst SHALL take priority over every other event, including mid-DEBOUNCE, mid-RELEASE and a publish in the same cycle.

Verification (SCAN_DIV = 4, DEBOUNCE_CNT = 2)
REQ-028 Reset: rst held 2 cycles, row = 4'hF -> col = 4'b1110; key_code, key_valid, key_down and overrun all 0.
REQ-029 Idle scan: row = 4'hF -> col steps 1110, 1101, 1011, 0111, 1110, every 4 clk cycles.
REQ-030 Press row 2 while col = 1101, held -> col frozen at 1101; key_code = 9, key_valid = 1 and key_down = 1 after 2 matching ticks; release -> key_down = 0 after 2 high ticks; scanning resumes at col = 1011.
REQ-031 Bounce: row 2 low for 1 tick, then high -> key_valid stays 0; col resumes stepping.
REQ-032 Two full presses (codes 9 then 0) without key_ack -> key_code = 9, overrun = 1; one key_ack pulse -> key_valid = 0, overrun = 0.
REQ-033 rst asserted mid-DEBOUNCE -> all outputs at reset values at that edge; no key_valid afterwards; publish coinciding with key_ack -> new code loaded, key_valid stays 1, overrun = 0.
